// File: rtl/comparator_bist.sv
// comparator_bist: in-system BIST that drives LFSR operand pairs into a magnitude
// comparator, waits a settle window, and checks its gt/lt/eq flags against a reference.
module comparator_bist #(
    parameter int          WIDTH       = 4,
    parameter int          NUM_VECTORS = 5,
    parameter int          SETTLE      = 1,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic             a_grt_b_in,
    input  logic             a_less_b_in,
    input  logic             a_eq_b_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      vec_count,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] err_a,
    output logic [WIDTH-1:0] err_b
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] LFSR_INIT   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  SETTLE_LOAD = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;
    localparam logic [16:0] LAST_COUNT  = 17'(NUM_VECTORS);

    state_t           r_state;
    state_t           w_nextState;
    logic [15:0]      r_lfsr;
    logic [7:0]       r_settleCnt;
    logic [WIDTH-1:0] r_aOut;
    logic [WIDTH-1:0] r_bOut;
    logic             r_pass;
    logic [15:0]      r_vecCount;
    logic [15:0]      r_errCount;
    logic [WIDTH-1:0] r_errA;
    logic [WIDTH-1:0] r_errB;

    logic [15:0]      w_lfsrNext;
    logic [WIDTH-1:0] w_bDrive;
    logic [2:0]       w_expFlags;
    logic             w_vecFail;
    logic             w_lastVec;
    logic [15:0]      w_errNext;

    assign w_lfsrNext = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    // Every fourth vector reuses the low LFSR slice for b so the equal case is exercised.
    assign w_bDrive   = (r_vecCount[1:0] == 2'b11) ? r_lfsr[WIDTH-1:0] : r_lfsr[2*WIDTH-1:WIDTH];
    assign w_expFlags = {r_aOut > r_bOut, r_aOut < r_bOut, r_aOut == r_bOut};
    assign w_vecFail  = ({a_grt_b_in, a_less_b_in, a_eq_b_in} != w_expFlags);
    assign w_lastVec  = (({1'b0, r_vecCount} + 17'd1) == LAST_COUNT);
    assign w_errNext  = (w_vecFail && (r_errCount != 16'hFFFF)) ? r_errCount + 16'd1 : r_errCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_DRIVE;
                end
            end
            S_DRIVE: begin
                busy        = 1'b1;
                w_nextState = (SETTLE == 0) ? S_CHECK : S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (r_settleCnt == 8'd0) begin
                    w_nextState = S_CHECK;
                end
            end
            S_CHECK: begin
                busy        = 1'b1;
                w_nextState = w_lastVec ? S_DONE : S_DRIVE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Pass is resolved on the last CHECK so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= LFSR_INIT;
            r_settleCnt <= 8'd0;
            r_aOut      <= '0;
            r_bOut      <= '0;
            r_pass      <= 1'b0;
            r_vecCount  <= 16'd0;
            r_errCount  <= 16'd0;
            r_errA      <= '0;
            r_errB      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_lfsr     <= LFSR_INIT;
                        r_pass     <= 1'b0;
                        r_vecCount <= 16'd0;
                        r_errCount <= 16'd0;
                        r_errA     <= '0;
                        r_errB     <= '0;
                    end
                end
                S_DRIVE: begin
                    r_aOut      <= r_lfsr[WIDTH-1:0];
                    r_bOut      <= w_bDrive;
                    r_lfsr      <= w_lfsrNext;
                    r_settleCnt <= SETTLE_LOAD;
                end
                S_SETTLE: begin
                    if (r_settleCnt != 8'd0) begin
                        r_settleCnt <= r_settleCnt - 8'd1;
                    end
                end
                S_CHECK: begin
                    r_vecCount <= r_vecCount + 16'd1;
                    r_errCount <= w_errNext;
                    if (w_vecFail && (r_errCount == 16'd0)) begin
                        r_errA <= r_aOut;
                        r_errB <= r_bOut;
                    end
                    if (w_lastVec) begin
                        r_pass <= (w_errNext == 16'd0);
                    end
                end
                S_DONE: begin
                    r_pass <= (r_errCount == 16'd0);
                end
                default: begin
                end
            endcase
        end
    end

    assign a_out     = r_aOut;
    assign b_out     = r_bOut;
    assign pass      = r_pass;
    assign vec_count = r_vecCount;
    assign err_count = r_errCount;
    assign err_a     = r_errA;
    assign err_b     = r_errB;

endmodule

// File: tb/tb_comparator_bist.sv
// tb_comparator_bist: scoreboard bench; a fault-injectable comparator model feeds the BIST
// and a reference model predicts operands, error counts, first-fail capture and timing.
module tb_comparator_bist;

    localparam int          NUM_A    = 5;
    localparam int          SETTLE_A = 1;
    localparam logic [15:0] SEED_A   = 16'hACE1;

    typedef struct {
        int a;
        int b;
        int err;
    } vecExp_t;

    typedef struct {
        int     vec;
        int     err;
        int     pass;
        int     errA;
        int     errB;
        longint acceptEdge;
    } runExp_t;

    logic clk = 1'b0;
    logic rst;
    longint edgeCount = 0;
    int checks = 0;
    int fails  = 0;

    // Main DUT (default parameters)
    logic       startA;
    logic [3:0] aA, bA, errAA, errBA;
    logic       gtA, ltA, eqA, busyA, doneA, passA;
    logic [15:0] vecA, errCntA;
    int         modeA = 0;

    // Aux DUT B: full 16-bit operand use, no settle window, zero seed
    logic       startB;
    logic [7:0] aB, bB, errAB, errBB;
    logic       gtB, ltB, eqB, busyB, doneB, passB;
    logic [15:0] vecB, errCntB;

    // Aux DUT C: seed 16'h1234, longer settle window
    logic       startC;
    logic [3:0] aC, bC, errAC, errBC;
    logic       gtC, ltC, eqC, busyC, doneC, passC;
    logic [15:0] vecC, errCntC;

    vecExp_t opQ[$];
    runExp_t resQ[$];
    int      refA[$];
    int      refB[$];
    int      lastPass;

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    comparator_bist #(.WIDTH(4), .NUM_VECTORS(NUM_A), .SETTLE(SETTLE_A), .SEED(SEED_A)) dutA (
        .clk(clk), .rst(rst), .start(startA), .a_out(aA), .b_out(bA),
        .a_grt_b_in(gtA), .a_less_b_in(ltA), .a_eq_b_in(eqA),
        .busy(busyA), .done(doneA), .pass(passA), .vec_count(vecA), .err_count(errCntA),
        .err_a(errAA), .err_b(errBA)
    );

    comparator_bist #(.WIDTH(8), .NUM_VECTORS(9), .SETTLE(0), .SEED(16'h0000)) dutB (
        .clk(clk), .rst(rst), .start(startB), .a_out(aB), .b_out(bB),
        .a_grt_b_in(gtB), .a_less_b_in(ltB), .a_eq_b_in(eqB),
        .busy(busyB), .done(doneB), .pass(passB), .vec_count(vecB), .err_count(errCntB),
        .err_a(errAB), .err_b(errBB)
    );

    comparator_bist #(.WIDTH(4), .NUM_VECTORS(8), .SETTLE(2), .SEED(16'h1234)) dutC (
        .clk(clk), .rst(rst), .start(startC), .a_out(aC), .b_out(bC),
        .a_grt_b_in(gtC), .a_less_b_in(ltC), .a_eq_b_in(eqC),
        .busy(busyC), .done(doneC), .pass(passC), .vec_count(vecC), .err_count(errCntC),
        .err_a(errAC), .err_b(errBC)
    );

    // Comparator behaviour per fault mode: 0 good, 1 all-zero, 2 all-one, 3 eq stuck 0, 4 gt/lt swapped.
    function automatic logic [2:0] flagsFor(input int mode, input int a, input int b);
        logic [2:0] t;
        t = {a > b, a < b, a == b};
        case (mode)
            1:       flagsFor = 3'b000;
            2:       flagsFor = 3'b111;
            3:       flagsFor = {t[2], t[1], 1'b0};
            4:       flagsFor = {t[1], t[2], t[0]};
            default: flagsFor = t;
        endcase
    endfunction

    always_comb {gtA, ltA, eqA} = flagsFor(modeA, int'(aA), int'(bA));
    always_comb {gtB, ltB, eqB} = {aB > bB, aB < bB, aB == bB};
    always_comb {gtC, ltC, eqC} = {aC > bC, aC < bC, aC == bC};

    function automatic void modelOperands(input logic [15:0] seed, input int width, input int n);
        int l;
        int mask;
        int a;
        l    = (seed == 16'h0000) ? 1 : int'(seed);
        mask = (1 << width) - 1;
        refA.delete();
        refB.delete();
        for (int i = 0; i < n; i++) begin
            a = l & mask;
            refA.push_back(a);
            refB.push_back((i % 4 == 3) ? a : ((l >> width) & mask));
            l = (l >> 1) ^ (((l & 1) != 0) ? 'hB400 : 0);
        end
    endfunction

    function automatic void pushRun(input int mode, input longint acceptEdge);
        runExp_t r;
        vecExp_t e;
        int errs;
        modeA = mode;
        modelOperands(SEED_A, 4, NUM_A);
        errs = 0;
        r.errA = 0;
        r.errB = 0;
        for (int i = 0; i < NUM_A; i++) begin
            if (flagsFor(mode, refA[i], refB[i]) != flagsFor(0, refA[i], refB[i])) begin
                if (errs == 0) begin
                    r.errA = refA[i];
                    r.errB = refB[i];
                end
                errs++;
            end
            e.a   = refA[i];
            e.b   = refB[i];
            e.err = errs;
            opQ.push_back(e);
        end
        r.vec        = NUM_A;
        r.err        = errs;
        r.pass       = (errs == 0) ? 1 : 0;
        r.acceptEdge = acceptEdge;
        lastPass     = r.pass;
        resQ.push_back(r);
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s: event not expected or not reached", name);
    endtask

    // Monitor: checks each completed vector and each done pulse of the main DUT.
    int prevVecA  = 0;
    bit prevDoneA = 1'b0;
    always @(negedge clk) begin
        vecExp_t e;
        runExp_t r;
        if (int'(vecA) != prevVecA) begin
            if (vecA != 16'd0) begin
                if (opQ.size() == 0) begin
                    reportFail("unexpected_vector");
                end else begin
                    e = opQ.pop_front();
                    checkOutput("vector_a", aA, e.a);
                    checkOutput("vector_b", bA, e.b);
                    checkOutput("running_err_count", errCntA, e.err);
                end
            end
            prevVecA = int'(vecA);
        end
        if (prevDoneA) checkOutput("done_single_cycle", doneA, 0);
        if (doneA) begin
            if (resQ.size() == 0) begin
                reportFail("unexpected_done");
            end else begin
                r = resQ.pop_front();
                checkOutput("final_vec_count", vecA, r.vec);
                checkOutput("final_err_count", errCntA, r.err);
                checkOutput("final_pass", passA, r.pass);
                checkOutput("err_a", errAA, r.errA);
                checkOutput("err_b", errBA, r.errB);
                checkOutput("done_latency", edgeCount - r.acceptEdge, NUM_A * (2 + SETTLE_A));
                checkOutput("busy_low_at_done", busyA, 0);
            end
        end
        prevDoneA = doneA;
    end

    task automatic checkResetState();
        checkOutput("reset_operands", {aA, bA}, 0);
        checkOutput("reset_flags", {busyA, doneA, passA}, 0);
        checkOutput("reset_counts", {vecA, errCntA}, 0);
        checkOutput("reset_err_ops", {errAA, errBA}, 0);
    endtask

    task automatic waitDone(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (doneA) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        reportFail("done_timeout");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        opQ.delete();
        resQ.delete();
    endtask

    task automatic applyStimulus(input int mode, input bit pulseMid, input bit startInDone);
        bit ok;
        pushRun(mode, edgeCount + 1);
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        checkOutput("busy_after_start", busyA, 1);
        if (pulseMid) begin
            repeat (3) @(negedge clk);
            startA = 1'b1;
            @(negedge clk);
            startA = 1'b0;
        end
        waitDone(ok);
        if (ok) begin
            if (startInDone) startA = 1'b1;
            @(negedge clk);
            startA = 1'b0;
            checkOutput("pass_holds", passA, lastPass);
            if (startInDone) begin
                @(negedge clk);
                checkOutput("start_in_done_ignored", busyA, 0);
            end
        end
    endtask

    task automatic runAux(input int which, input int width, input int n, input int settle,
                          input logic [15:0] seed);
        int va, vb, vc, dn, ps, ec, ea, eb, prevVec;
        longint accept;
        bit seen;
        modelOperands(seed, width, n);
        accept = edgeCount + 1;
        if (which == 0) startB = 1'b1;
        else            startC = 1'b1;
        @(negedge clk);
        startB  = 1'b0;
        startC  = 1'b0;
        prevVec = 0;
        seen    = 1'b0;
        for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
            if (which == 0) begin
                va = aB; vb = bB; vc = vecB; dn = doneB; ps = passB; ec = errCntB; ea = errAB; eb = errBB;
            end else begin
                va = aC; vb = bC; vc = vecC; dn = doneC; ps = passC; ec = errCntC; ea = errAC; eb = errBC;
            end
            if (vc != prevVec && vc != 0) begin
                if (vc <= refA.size()) begin
                    checkOutput("aux_vector_a", va, refA[vc-1]);
                    checkOutput("aux_vector_b", vb, refB[vc-1]);
                end
                if (which == 1 && vc == 1) begin
                    checkOutput("seed1234_first_a", va, 4);
                    checkOutput("seed1234_first_b", vb, 3);
                end
                prevVec = vc;
            end
            if (dn != 0) begin
                seen = 1'b1;
                checkOutput("aux_latency", edgeCount - accept, n * (2 + settle));
                checkOutput("aux_vec_count", vc, n);
                checkOutput("aux_err_count", ec, 0);
                checkOutput("aux_pass", ps, 1);
                checkOutput("aux_err_ops", {ea, eb}, 0);
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) reportFail("aux_done_timeout");
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        rst    = 1'b1;
        startA = 1'b0;
        startB = 1'b0;
        startC = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState();
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed runs");
        for (int m = 0; m < 5; m++) applyStimulus(m, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(3, 1'b0, 1'b1);

        $display("[TB] held start back-to-back");
        pushRun(0, edgeCount + 1);
        startA = 1'b1;
        @(negedge clk);
        checkOutput("busy_held_start", busyA, 1);
        waitDone(ok);
        if (ok) begin
            pushRun(2, edgeCount + 2);
            @(negedge clk);
            @(negedge clk);
            startA = 1'b0;
            checkOutput("held_start_restart", busyA, 1);
            waitDone(ok);
            @(negedge clk);
            checkOutput("pass_after_held_run", passA, lastPass);
        end
        startA = 1'b0;

        $display("[TB] reset mid-run");
        pushRun(0, edgeCount + 1);
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkResetState();
        rst = 1'b0;
        opQ.delete();
        resQ.delete();
        repeat (3) @(negedge clk);
        checkOutput("no_done_after_abort", doneA, 0);
        applyStimulus(0, 1'b0, 1'b0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] parameter variants");
        runAux(0, 8, 9, 0, 16'h0000);
        runAux(1, 4, 8, 2, 16'h1234);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
